// File: rtl/bin_morph3x3.sv
// ---------------------------------------------------------------------------
// bin_morph3x3
//   3x3 binary morphology on the 1-bit edge stream: dilation (OR of the
//   window) when MODE=0, erosion (AND of the window) when MODE=1.
//   The output for the input pixel at (r,c) is the result centred at
//   (r-1,c-1). Window taps that fall above row 0 or left of column 0 are
//   replaced with the neutral value for the mode, so borders neither grow
//   nor shrink.
//
// Ports
//   clk, rst                  pixel clock, synchronous active-high reset
//   din, din_vld              binary pixel and its valid
//   din_sop, din_eop          first/last pixel of the frame (qualified by vld)
//   dout, dout_vld            filtered pixel and its valid (2 clk latency)
//   dout_sop, dout_eop        frame markers of the same pixel
//   frame_err                 one-cycle pulse: frame length != IMG_W*IMG_H
// ---------------------------------------------------------------------------
module bin_morph3x3 #(
   parameter int IMG_W = 1280,
   parameter int IMG_H = 720,
   parameter int MODE  = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic din_vld,
   input  logic din_sop,
   input  logic din_eop,
   output logic dout,
   output logic dout_vld,
   output logic dout_sop,
   output logic dout_eop,
   output logic frame_err
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   // neutral value for out-of-image taps
   localparam logic PAD = (MODE != 0);

   typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   col_q, col_d, pos_c;
   logic [RW-1:0]   row_q, row_d, pos_r;
   logic            accept, last_px, err;

   // line buffers: lb1 holds row-1, lb0 holds row-2 (no reset, taps are masked)
   logic            lb0_q [IMG_W];
   logic            lb1_q [IMG_W];
   logic            tap1, tap2;

   // window columns, [0] newest; each column is {row-2, row-1, row}
   logic [2:0][2:0] win_q;
   logic            s1_vld_q, s1_sop_q, s1_eop_q, s1_err_q;
   logic            s1_cge1_q, s1_cge2_q;
   logic [8:0]      taps;
   logic            res;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   // A pixel landing on the last position ends the frame even without eop.
   always_comb begin
      state_d = state_q;
      if (accept) state_d = (din_eop || last_px) ? S_IDLE : S_ACTIVE;
   end

   // ---------------- FSM: outputs / position control ----------------
   // sop always restarts at (0,0), whether idle or mid-frame.
   always_comb begin
      accept  = din_vld && (din_sop || (state_q == S_ACTIVE));
      pos_c   = din_sop ? '0 : col_q;
      pos_r   = din_sop ? '0 : row_q;
      last_px = (pos_r == ROW_LAST) && (pos_c == COL_LAST);
      err     = accept && ((din_sop && (state_q == S_ACTIVE)) || (din_eop != last_px));
      col_d   = col_q;
      row_d   = row_q;
      if (accept) begin
         if (pos_c == COL_LAST) begin
            col_d = '0;
            row_d = pos_r + 1'b1;
         end else begin
            col_d = pos_c + 1'b1;
            row_d = pos_r;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // ---------------- line buffers ----------------
   always_ff @(posedge clk) begin
      if (accept) begin
         lb0_q[pos_c] <= lb1_q[pos_c];
         lb1_q[pos_c] <= din;
      end
   end

   // row masking happens on entry, since a column keeps its row forever
   assign tap1 = (pos_r != '0)     ? lb1_q[pos_c] : PAD;
   assign tap2 = (pos_r > RW'(1))  ? lb0_q[pos_c] : PAD;

   // ---------------- stage 1: window shift ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         win_q     <= '0;
         s1_vld_q  <= 1'b0;
         s1_sop_q  <= 1'b0;
         s1_eop_q  <= 1'b0;
         s1_err_q  <= 1'b0;
         s1_cge1_q <= 1'b0;
         s1_cge2_q <= 1'b0;
      end else begin
         s1_vld_q <= accept;
         s1_sop_q <= accept && din_sop;
         s1_eop_q <= accept && din_eop;
         s1_err_q <= err;
         if (accept) begin
            win_q[2]  <= win_q[1];
            win_q[1]  <= win_q[0];
            win_q[0]  <= {tap2, tap1, din};
            // older columns belong to the previous line near the left edge
            s1_cge1_q <= (pos_c != '0);
            s1_cge2_q <= (pos_c > CW'(1));
         end
      end
   end

   // ---------------- stage 2: reduction ----------------
   always_comb begin
      taps = {s1_cge2_q ? win_q[2] : {3{PAD}},
              s1_cge1_q ? win_q[1] : {3{PAD}},
              win_q[0]};
      res  = (MODE != 0) ? (&taps) : (|taps);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout      <= 1'b0;
         dout_vld  <= 1'b0;
         dout_sop  <= 1'b0;
         dout_eop  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         dout      <= s1_vld_q && res;
         dout_vld  <= s1_vld_q;
         dout_sop  <= s1_sop_q;
         dout_eop  <= s1_eop_q;
         frame_err <= s1_err_q;
      end
   end

endmodule
